// File: rtl/hdng_err_if.sv
// Heading error generator bus: raw heading samples in, saturated/validated error out.
interface hdng_err_if;
   logic        moving;
   logic        hdng_vld;
   logic [11:0] heading;
   logic [11:0] dsrd_hdng;
   logic [9:0]  err_sat;
   logic        err_vld;
   logic        at_hdng;

   modport master (output moving, hdng_vld, heading, dsrd_hdng,
                   input  err_sat, err_vld, at_hdng);
   modport slave  (input  moving, hdng_vld, heading, dsrd_hdng,
                   output err_sat, err_vld, at_hdng);
endinterface

// File: rtl/hdng_err_gen.sv
// Heading PID front end: wrapped, saturated, blanked heading error plus settle flag.
// Optional two-sample averaging of the error is enabled by defining HDNG_ERR_AVG_EN.
module hdng_err_gen #(
   parameter int BLANK_SMPLS  = 4,
   parameter int SETTLE_SMPLS = 8,
   parameter int AT_THRESH    = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   hdng_err_if.slave  bus
);
   localparam logic [7:0]         BLANK_N  = 8'(BLANK_SMPLS);
   localparam logic [7:0]         SETTLE_N = 8'(SETTLE_SMPLS);
   localparam logic signed [11:0] THR      = 12'(AT_THRESH);

   typedef enum logic [1:0] {IDLE, BLANK, TRACK} state_t;

   state_t      state_q, state_d;
   logic [7:0]  blank_cnt_q, blank_cnt_d;
   logic [7:0]  settle_cnt_q, settle_cnt_d;
   logic [11:0] dsrd_q, dsrd_d;
   logic [9:0]  err_sat_q, err_sat_d;
   logic        err_vld_q, err_vld_d;
   logic        at_hdng_q, at_hdng_d;
`ifdef HDNG_ERR_AVG_EN
   logic [11:0] prev_q, prev_d;
   logic        have_prev_q, have_prev_d;
   logic signed [12:0] sum;
`endif

   logic [11:0]        err_raw;
   logic signed [12:0] val;
   logic [9:0]         sat_val;
   logic signed [11:0] sat_x;
   logic               inband;

   function automatic logic [9:0] sat10(input logic signed [12:0] v);
      if (v > 13'sd511)       return 10'h1FF;
      else if (v < -13'sd512) return 10'h200;
      else                    return v[9:0];
   endfunction

   // 12-bit wrap gives the shortest-path error for free
   assign err_raw = bus.heading - bus.dsrd_hdng;

`ifdef HDNG_ERR_AVG_EN
   assign sum = $signed({err_raw[11], err_raw}) + $signed({prev_q[11], prev_q});
   assign val = have_prev_q ? (sum >>> 1) : $signed({err_raw[11], err_raw});
`else
   assign val = $signed({err_raw[11], err_raw});
`endif

   assign sat_val = sat10(val);
   assign sat_x   = 12'(signed'(sat_val));
   assign inband  = (sat_x <= THR) && (sat_x >= -THR);

   always_comb begin
      state_d      = state_q;
      blank_cnt_d  = blank_cnt_q;
      settle_cnt_d = settle_cnt_q;
      dsrd_d       = bus.dsrd_hdng;
      err_sat_d    = err_sat_q;
      err_vld_d    = 1'b0;
      at_hdng_d    = at_hdng_q;
`ifdef HDNG_ERR_AVG_EN
      prev_d       = prev_q;
      have_prev_d  = have_prev_q;
`endif
      if (!bus.moving) begin
         state_d      = IDLE;
         blank_cnt_d  = 8'd0;
         settle_cnt_d = 8'd0;
         err_sat_d    = 10'd0;
         at_hdng_d    = 1'b0;
`ifdef HDNG_ERR_AVG_EN
         prev_d       = 12'd0;
         have_prev_d  = 1'b0;
`endif
      end else begin
         unique case (state_q)
            IDLE: begin
               state_d     = (BLANK_SMPLS > 0) ? BLANK : TRACK;
               blank_cnt_d = 8'd0;
            end
            BLANK: begin
               // the sample that completes blanking is swallowed too
               if (bus.hdng_vld) begin
                  if (blank_cnt_q + 8'd1 == BLANK_N) begin
                     state_d     = TRACK;
                     blank_cnt_d = 8'd0;
                  end else begin
                     blank_cnt_d = blank_cnt_q + 8'd1;
                  end
               end
            end
            TRACK: begin
               if (bus.hdng_vld) begin
                  err_sat_d = sat_val;
                  err_vld_d = 1'b1;
                  if (!inband)                   settle_cnt_d = 8'd0;
                  else if (settle_cnt_q != SETTLE_N) settle_cnt_d = settle_cnt_q + 8'd1;
                  at_hdng_d = (settle_cnt_d == SETTLE_N);
`ifdef HDNG_ERR_AVG_EN
                  prev_d      = err_raw;
                  have_prev_d = 1'b1;
`endif
               end
            end
            default: state_d = IDLE;
         endcase
         // a new setpoint invalidates any settle progress
         if (bus.dsrd_hdng != dsrd_q) begin
            settle_cnt_d = 8'd0;
            at_hdng_d    = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         blank_cnt_q  <= 8'd0;
         settle_cnt_q <= 8'd0;
         dsrd_q       <= 12'd0;
         err_sat_q    <= 10'd0;
         err_vld_q    <= 1'b0;
         at_hdng_q    <= 1'b0;
`ifdef HDNG_ERR_AVG_EN
         prev_q       <= 12'd0;
         have_prev_q  <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         blank_cnt_q  <= blank_cnt_d;
         settle_cnt_q <= settle_cnt_d;
         dsrd_q       <= dsrd_d;
         err_sat_q    <= err_sat_d;
         err_vld_q    <= err_vld_d;
         at_hdng_q    <= at_hdng_d;
`ifdef HDNG_ERR_AVG_EN
         prev_q       <= prev_d;
         have_prev_q  <= have_prev_d;
`endif
      end
   end

   assign bus.err_sat = err_sat_q;
   assign bus.err_vld = err_vld_q;
   assign bus.at_hdng = at_hdng_q;
endmodule

// File: tb/tb_hdng_err_gen.sv
// Directed bench for hdng_err_gen: blanking, wrap/saturation table, settling, dsrd change, moving drop, reset.
module tb_hdng_err_gen;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   hdng_err_if ia();
   hdng_err_if ib();

   hdng_err_gen #(.BLANK_SMPLS(4), .SETTLE_SMPLS(8), .AT_THRESH(32)) u_dut (
      .clk(clk), .rst_n(rst_n), .bus(ia.slave));
   hdng_err_gen #(.BLANK_SMPLS(0), .SETTLE_SMPLS(8), .AT_THRESH(32)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .bus(ib.slave));

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [11:0] heading;
      logic [11:0] dsrd;
      logic [9:0]  exp_sat;
   } vec_t;
   vec_t vecs[11];

   // bench-side model of the tracking path of u_dut
   int m_prev = 0;
   bit m_have = 0;
   int m_sc = 0;

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [9:0] bsat(input int v);
      logic [31:0] w;
      w = v;
      if (v > 511)  return 10'h1FF;
      if (v < -512) return 10'h200;
      return w[9:0];
   endfunction

   // blanked strobe on u_dut: must produce no err_vld
   task automatic strobe_blank(input string nm);
      ia.heading  = 12'h010;
      ia.hdng_vld = 1'b1;
      tick;
      chk(nm, 16'(ia.err_vld), 16'd0);
      ia.hdng_vld = 1'b0;
      tick;
      chk(nm, 16'(ia.err_vld), 16'd0);
   endtask

   // tracked strobe on u_dut, checked against the model
   task automatic strobe_track(input string nm, input logic [11:0] h);
      logic [11:0] d;
      int cur, v, es_i;
      logic [9:0] es;
      d   = h - ia.dsrd_hdng;
      cur = int'($signed(d));
`ifdef HDNG_ERR_AVG_EN
      v = m_have ? ((cur + m_prev) >>> 1) : cur;
`else
      v = cur;
`endif
      es   = bsat(v);
      es_i = int'($signed(es));
      if (es_i > 32 || es_i < -32) m_sc = 0;
      else if (m_sc < 8)           m_sc++;
      m_prev = cur;
      m_have = 1;
      ia.heading  = h;
      ia.hdng_vld = 1'b1;
      tick;
      chk({nm, "_vld"}, 16'(ia.err_vld), 16'd1);
      chk({nm, "_sat"}, 16'(ia.err_sat), 16'(es));
      chk({nm, "_at"},  16'(ia.at_hdng), 16'(m_sc == 8));
      ia.hdng_vld = 1'b0;
      tick;
      chk({nm, "_pulse"}, 16'(ia.err_vld), 16'd0);
   endtask

   initial begin
      vecs[0]  = '{12'h7FF, 12'h801, 10'h3FE};
      vecs[1]  = '{12'h400, 12'h000, 10'h1FF};
      vecs[2]  = '{12'hC00, 12'h000, 10'h200};
      vecs[3]  = '{12'h000, 12'h000, 10'h000};
      vecs[4]  = '{12'h1FF, 12'h000, 10'h1FF};
      vecs[5]  = '{12'h200, 12'h000, 10'h1FF};
      vecs[6]  = '{12'hE00, 12'h000, 10'h200};
      vecs[7]  = '{12'hDFF, 12'h000, 10'h200};
      vecs[8]  = '{12'h010, 12'h000, 10'h010};
      vecs[9]  = '{12'h005, 12'h00A, 10'h3FB};
      vecs[10] = '{12'h801, 12'h7FF, 10'h002};

      ia.moving = 0; ia.hdng_vld = 0; ia.heading = 0; ia.dsrd_hdng = 0;
      ib.moving = 0; ib.hdng_vld = 0; ib.heading = 0; ib.dsrd_hdng = 0;
      tick; tick;
      chk("rst_sat", 16'(ia.err_sat), 16'd0);
      chk("rst_vld", 16'(ia.err_vld), 16'd0);
      chk("rst_at",  16'(ia.at_hdng), 16'd0);
      rst_n = 1'b1;
      tick;

      // blanking: four suppressed, fifth emitted
      ia.moving = 1'b1;
      tick; tick;
      for (int i = 0; i < 4; i++) strobe_blank("blank");
      m_have = 0; m_sc = 0;
      strobe_track("first", 12'h010);

      // settling: new setpoint clears progress, then err=20
      ia.dsrd_hdng = 12'h010;
      m_sc = 0;
      tick;
      chk("dsrd_at", 16'(ia.at_hdng), 16'd0);
      for (int i = 0; i < 8; i++) strobe_track("settle1", 12'h024);
      chk("settled1", 16'(ia.at_hdng), 16'd1);
      strobe_track("oob", 12'h074);
      chk("oob_at", 16'(ia.at_hdng), 16'd0);
      for (int i = 0; i < 9; i++) strobe_track("settle2", 12'h024);
      chk("settled2", 16'(ia.at_hdng), 16'd1);

      // setpoint change without a strobe
      ia.dsrd_hdng = 12'h015;
      m_sc = 0;
      tick;
      chk("chg_at",  16'(ia.at_hdng), 16'd0);
      chk("chg_sat", 16'(ia.err_sat), 16'd20);
      tick;
      chk("chg_hold", 16'(ia.err_sat), 16'd20);
      strobe_track("post_chg", 12'h024);

      // moving drop wins over a simultaneous strobe
      ia.moving   = 1'b0;
      ia.heading  = 12'h030;
      ia.hdng_vld = 1'b1;
      tick;
      chk("drop_vld", 16'(ia.err_vld), 16'd0);
      chk("drop_sat", 16'(ia.err_sat), 16'd0);
      chk("drop_at",  16'(ia.at_hdng), 16'd0);
      ia.hdng_vld = 1'b0;
      ia.moving   = 1'b1;
      tick; tick;
      for (int i = 0; i < 4; i++) strobe_blank("reblank");
      m_have = 0; m_sc = 0;
      strobe_track("reblank_first", 12'h030);

      // async reset mid-operation, then blanking again with moving still high
      #2 rst_n = 1'b0;
      #1;
      chk("async_sat", 16'(ia.err_sat), 16'd0);
      chk("async_at",  16'(ia.at_hdng), 16'd0);
      tick;
      rst_n = 1'b1;
      tick; tick;
      for (int i = 0; i < 4; i++) strobe_blank("rst_blank");
      m_have = 0; m_sc = 0;
      strobe_track("rst_first", 12'h020);

      // wrap and saturation table on the unblanked instance
      foreach (vecs[i]) begin
         ib.moving = 1'b0;
         tick;
         ib.moving    = 1'b1;
         ib.heading   = vecs[i].heading;
         ib.dsrd_hdng = vecs[i].dsrd;
         tick;
         ib.hdng_vld = 1'b1;
         tick;
         chk($sformatf("tbl%0d_vld", i), 16'(ib.err_vld), 16'd1);
         chk($sformatf("tbl%0d_sat", i), 16'(ib.err_sat), 16'(vecs[i].exp_sat));
         ib.hdng_vld = 1'b0;
      end

      // averaging: errors 100 then 200
      ib.moving = 1'b0;
      tick;
      ib.moving    = 1'b1;
      ib.dsrd_hdng = 12'h000;
      tick;
      ib.heading  = 12'd100;
      ib.hdng_vld = 1'b1;
      tick;
      chk("avg_first", 16'(ib.err_sat), 16'd100);
      ib.heading = 12'd200;
      tick;
      chk("avg_vld", 16'(ib.err_vld), 16'd1);
`ifdef HDNG_ERR_AVG_EN
      chk("avg_second", 16'(ib.err_sat), 16'd150);
`else
      chk("avg_second", 16'(ib.err_sat), 16'd200);
`endif
      ib.hdng_vld = 1'b0;
      tick;
      chk("avg_pulse", 16'(ib.err_vld), 16'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/hdng_err_gen.md
Name: hdng_err_gen

Overview:
- Upstream stage of the heading PID: turns raw heading samples into the saturated, validated error consumed by the integral, proportional and derivative terms (err_sat, err_vld).
- Computes the wrapped heading error against the desired heading and saturates it to 10 bits signed.
- Blanks the first samples after motion starts.
- Flags when the heading has settled.

Parameters:
- BLANK_SMPLS, 4: number of hdng_vld samples suppressed after moving rises (0 = no blanking).
- SETTLE_SMPLS, 8: consecutive in-band samples required to assert at_hdng (range 1..255).
- AT_THRESH, 32: in-band limit; a sample is in-band when |err_sat| <= AT_THRESH.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- moving  in  1  high while the drive is enabled; low clears all tracking state
- hdng_vld  in  1  one-cycle strobe: heading holds a new sample
- heading  in  12  signed actual heading; 4096 counts = full circle
- dsrd_hdng  in  12  signed desired heading, same units
- err_sat  out  10  signed saturated error, registered
- err_vld  out  1  one-cycle strobe: err_sat is new and valid
- at_hdng  out  1  level: heading settled within AT_THRESH

Behaviour:
- Reset: as stated under Ports, clk is the one clock and rst_n is an asynchronous active-low reset. On reset, err_sat=0, err_vld=0, at_hdng=0, FSM in IDLE, and all counters and history registers are 0.
- Arithmetic:
  - err_raw = heading - dsrd_hdng, computed in 12-bit two's complement. It wraps modulo 4096, so the shortest-path error is produced naturally: 0x7FF - 0x801 = -2.
  - Saturation: err_raw > 511 gives 511 (0x1FF). err_raw < -512 gives -512 (0x200). Otherwise err_sat is err_raw[9:0].
- Latency: one cycle. A hdng_vld that is accepted in cycle N gives err_vld=1 and the new err_sat in cycle N+1. err_vld is never high for two consecutive cycles unless hdng_vld is.
- err_sat holds its last value between strobes.
- FSM states:
  - IDLE (moving=0): err_vld=0, at_hdng=0, blank and settle counters cleared, err_sat cleared to 0.
    - moving=1 and BLANK_SMPLS>0: go to BLANK.
    - moving=1 and BLANK_SMPLS=0: go to TRACK.
  - BLANK: each hdng_vld increments blank_cnt. No err_vld and no err_sat update.
    - When the BLANK_SMPLS-th sample is counted: go to TRACK. That sample itself is not emitted.
  - TRACK: each hdng_vld updates err_sat and pulses err_vld the next cycle.
- moving=0 in any state:
  - Next state is IDLE.
  - It wins over a simultaneous hdng_vld: no err_vld, outputs cleared the following cycle.
- Settle logic (TRACK only):
  - settle_cnt increments on each emitted in-band sample and saturates at SETTLE_SMPLS.
  - An out-of-band sample clears it to 0.
  - at_hdng = (settle_cnt == SETTLE_SMPLS), registered, and updates in the same cycle as err_vld.
- dsrd_hdng change: dsrd_hdng is registered internally. Any cycle where dsrd_hdng differs from the stored value clears settle_cnt and at_hdng the next cycle. The FSM state and err_sat are unchanged.
- Reset asserted mid-operation: all outputs drop to reset values immediately (async). After rst_n rises, the FSM restarts in IDLE, even if moving is already high; BLANK then runs again.

Optional Feature:
- Macro: HDNG_ERR_AVG_EN.
- Defined:
  - err_sat is the saturation of (err_raw_cur + err_raw_prev) >>> 1, computed with a 13-bit sum (arithmetic shift).
  - err_raw_prev is updated on every TRACK sample and is cleared on entry to TRACK.
  - The first TRACK sample uses err_raw_cur alone.
  - Latency stays one cycle.
- Undefined: no history register; err_sat comes directly from the current sample.

Test Plan:
- Reset and blank: rst_n low, then moving=1, then 4 hdng_vld with heading=0x010, dsrd=0 -> err_vld never asserted. 5th strobe -> err_vld=1 one cycle later, err_sat=16.
- Wrap and saturation (BLANK_SMPLS=0): heading=0x7FF, dsrd=0x801 -> err_sat=-2. heading=0x400, dsrd=0 -> 511. heading=0xC00, dsrd=0 -> -512.
- Settling (SETTLE_SMPLS=8): 8 strobes with err=20 -> at_hdng=1 with the 8th err_vld. Then 1 strobe with err=40 -> at_hdng=0. Then 8 more in-band strobes -> at_hdng=1 again.
- dsrd change while at_hdng=1: dsrd_hdng goes 0 to 0x005 with no strobe -> at_hdng=0 next cycle; err_sat unchanged until the next strobe.
- moving dropped in the same cycle as hdng_vld -> no err_vld, err_sat=0 and at_hdng=0 next cycle. Raising moving again -> BLANK is re-entered (4 samples suppressed).
- HDNG_ERR_AVG_EN defined, BLANK_SMPLS=0: samples with errors 100 then 200 -> err_sat=100 then 150. Same stimulus undefined -> 100 then 200.
